// File: rtl/pipeline_hazard_ctrl.sv
// Issue and hazard controller for the 8-register pipelined core: tracks EX/MEM/WB,
// stalls on load-use, and registers operand-forwarding selects for the EX stage.
module pipeline_hazard_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  in_opcode,
   input  logic [2:0]  in_rd,
   input  logic [2:0]  in_rs,
   input  logic [2:0]  in_rt,
   input  logic        flush,
   output logic        ex_valid,
   output logic [1:0]  ex_opcode,
   output logic [2:0]  ex_rd,
   output logic [1:0]  fwd_a_sel,
   output logic [1:0]  fwd_b_sel,
   output logic        mem_valid,
   output logic [2:0]  mem_rd,
   output logic        wb_en,
   output logic [2:0]  wb_rd,
   output logic [15:0] stall_cnt
);

   localparam logic [1:0] OP_LOAD_IMM = 2'b00;
   localparam logic [1:0] OP_ALU      = 2'b01;
   localparam logic [1:0] OP_LOAD_MEM = 2'b10;
   localparam logic [1:0] OP_STORE    = 2'b11;

   localparam logic [1:0] SEL_RF  = 2'b00;
   localparam logic [1:0] SEL_MEM = 2'b01;
   localparam logic [1:0] SEL_WB  = 2'b10;

   logic [1:0] mem_op_r;
   logic       use_rs_s;
   logic       use_rt_s;
   logic       hazard_s;
   logic       accept_s;
   logic [1:0] fwd_a_s;
   logic [1:0] fwd_b_s;

   function automatic logic writes_rd(input logic [1:0] op);
      return (op != OP_STORE);
   endfunction

   function automatic logic uses_rs(input logic [1:0] op);
      logic r;
      case (op)
         OP_LOAD_IMM: r = 1'b0;
         OP_ALU:      r = 1'b1;
         OP_LOAD_MEM: r = 1'b1;
         OP_STORE:    r = 1'b1;
         default:     r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic uses_rt(input logic [1:0] op);
      logic r;
      case (op)
         OP_ALU:   r = 1'b1;
         OP_STORE: r = 1'b1;
         default:  r = 1'b0;
      endcase
      return r;
   endfunction

   // The younger producer (currently in EX, next in MEM) wins over the older one.
   function automatic logic [1:0] fwd_sel(
      input logic       used,
      input logic [2:0] src,
      input logic       p_ex_v,
      input logic [1:0] p_ex_op,
      input logic [2:0] p_ex_rd,
      input logic       p_mem_v,
      input logic [1:0] p_mem_op,
      input logic [2:0] p_mem_rd
   );
      logic [1:0] sel;
      sel = SEL_RF;
      if (!used) begin
         sel = SEL_RF;
      end else if (p_ex_v && writes_rd(p_ex_op) && (p_ex_rd == src)) begin
         sel = SEL_MEM;
      end else if (p_mem_v && writes_rd(p_mem_op) && (p_mem_rd == src)) begin
         sel = SEL_WB;
      end else begin
         sel = SEL_RF;
      end
      return sel;
   endfunction

   // Hazard detection, issue handshake and forwarding decision for the decode slot
   always_comb begin
      use_rs_s = uses_rs(in_opcode);
      use_rt_s = uses_rt(in_opcode);
      hazard_s = in_valid && ex_valid && (ex_opcode == OP_LOAD_MEM) &&
                 ((use_rs_s && (in_rs == ex_rd)) || (use_rt_s && (in_rt == ex_rd)));
      in_ready = !hazard_s && !flush;
      accept_s = in_valid && in_ready;
      fwd_a_s  = fwd_sel(use_rs_s, in_rs, ex_valid, ex_opcode, ex_rd,
                         mem_valid, mem_op_r, mem_rd);
      fwd_b_s  = fwd_sel(use_rt_s, in_rt, ex_valid, ex_opcode, ex_rd,
                         mem_valid, mem_op_r, mem_rd);
   end

   // Stage registers; the pipeline never freezes, a stall or flush only inserts bubbles
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid  <= 1'b0;
         ex_opcode <= 2'b00;
         ex_rd     <= 3'd0;
         fwd_a_sel <= SEL_RF;
         fwd_b_sel <= SEL_RF;
         mem_valid <= 1'b0;
         mem_op_r  <= 2'b00;
         mem_rd    <= 3'd0;
         wb_en     <= 1'b0;
         wb_rd     <= 3'd0;
         stall_cnt <= 16'd0;
      end else begin
         wb_en <= mem_valid && writes_rd(mem_op_r);
         wb_rd <= mem_rd;
         if (flush) begin
            mem_valid <= 1'b0;
            mem_op_r  <= 2'b00;
            mem_rd    <= 3'd0;
         end else begin
            mem_valid <= ex_valid;
            mem_op_r  <= ex_opcode;
            mem_rd    <= ex_rd;
         end
         if (accept_s) begin
            ex_valid  <= 1'b1;
            ex_opcode <= in_opcode;
            ex_rd     <= in_rd;
            fwd_a_sel <= fwd_a_s;
            fwd_b_sel <= fwd_b_s;
         end else begin
            ex_valid  <= 1'b0;
            ex_opcode <= 2'b00;
            ex_rd     <= 3'd0;
            fwd_a_sel <= SEL_RF;
            fwd_b_sel <= SEL_RF;
         end
         if (hazard_s && !flush && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
         end else begin
            stall_cnt <= stall_cnt;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: expected EX records and register writes
// are queued as instructions are issued and compared when they emerge.
module tb_pipeline_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_opcode;
   logic [2:0]  in_rd;
   logic [2:0]  in_rs;
   logic [2:0]  in_rt;
   logic        flush;
   logic        ex_valid;
   logic [1:0]  ex_opcode;
   logic [2:0]  ex_rd;
   logic [1:0]  fwd_a_sel;
   logic [1:0]  fwd_b_sel;
   logic        mem_valid;
   logic [2:0]  mem_rd;
   logic        wb_en;
   logic [2:0]  wb_rd;
   logic [15:0] stall_cnt;

   int tests_run = 0;
   int tests_failed = 0;

   typedef struct packed {
      logic [1:0] op;
      logic [2:0] rd;
      logic [1:0] fa;
      logic [1:0] fb;
   } ex_rec_t;

   typedef struct packed {
      logic [1:0] op;
      logic [2:0] rd;
      logic [2:0] rs;
      logic [2:0] rt;
      logic [1:0] fa;
      logic [1:0] fb;
   } stim_t;

   ex_rec_t    ex_q[$];
   logic [2:0] wb_q[$];
   ex_rec_t    exp_e;
   logic [2:0] exp_w;

   pipeline_hazard_ctrl dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
      .flush(flush), .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_rd(ex_rd),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .mem_valid(mem_valid),
      .mem_rd(mem_rd), .wb_en(wb_en), .wb_rd(wb_rd), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0; flush = 1'b0; in_opcode = 2'b00;
      in_rd = 3'd0; in_rs = 3'd0; in_rt = 3'd0;
   endtask

   task automatic drive(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs,
                        input logic [2:0] rt);
      in_valid = 1'b1; flush = 1'b0; in_opcode = op; in_rd = rd; in_rs = rs; in_rt = rt;
   endtask

   // Drive an instruction expected to be accepted and record what it must produce.
   task automatic put(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs,
                      input logic [2:0] rt, input logic [1:0] fa, input logic [1:0] fb);
      drive(op, rd, rs, rt);
      ex_q.push_back({op, rd, fa, fb});
      if (op != 2'b11) wb_q.push_back(rd);
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ex_q.delete();
      wb_q.delete();
   endtask

   task automatic test_reset();
      do_reset();
      tests_run++;
      if ({in_ready, ex_valid, ex_opcode, ex_rd, fwd_a_sel, fwd_b_sel, mem_valid, mem_rd,
           wb_en, wb_rd, stall_cnt} !== {1'b1, 34'd0}) begin
         tests_failed++;
         $display("FAIL reset_state: got rdy=%0b exv=%0b memv=%0b wben=%0b cnt=%0d required rdy=1 all else 0",
                  in_ready, ex_valid, mem_valid, wb_en, stall_cnt);
      end
      for (int i = 1; i <= 3; i++) begin
         put(2'b01, 3'(i), 3'd7, 3'd7, 2'b00, 2'b00);
         tick();
         exp_e = ex_q.pop_front();
         tests_run++;
         if ({ex_valid, ex_opcode, ex_rd, fwd_a_sel, fwd_b_sel} !== {1'b1, exp_e}) begin
            tests_failed++;
            $display("FAIL reset_fill_ex: got %h required %h",
                     {ex_valid, ex_opcode, ex_rd, fwd_a_sel, fwd_b_sel}, {1'b1, exp_e});
         end
      end
      exp_w = wb_q.pop_front();
      tests_run++;
      if ({mem_valid, mem_rd, wb_en, wb_rd} !== {1'b1, 3'd2, 1'b1, exp_w}) begin
         tests_failed++;
         $display("FAIL reset_fill_mem_wb: got memv=%0b memrd=%0d wben=%0b wbrd=%0d required 1 2 1 %0d",
                  mem_valid, mem_rd, wb_en, wb_rd, exp_w);
      end
      idle();
      rst = 1'b1;
      tick();
      tests_run++;
      if ({in_ready, ex_valid, ex_opcode, ex_rd, fwd_a_sel, fwd_b_sel, mem_valid, mem_rd,
           wb_en, wb_rd, stall_cnt} !== {1'b1, 34'd0}) begin
         tests_failed++;
         $display("FAIL reset_midstream: got exv=%0b memv=%0b wben=%0b exrd=%0d memrd=%0d wbrd=%0d required all 0",
                  ex_valid, mem_valid, wb_en, ex_rd, mem_rd, wb_rd);
      end
      rst = 1'b0;
      tick();
      tests_run++;
      if ({ex_valid, mem_valid, wb_en} !== 3'b000) begin
         tests_failed++;
         $display("FAIL reset_no_write: got exv=%0b memv=%0b wben=%0b required 0 0 0",
                  ex_valid, mem_valid, wb_en);
      end
   endtask

   task automatic test_forward_distance();
      logic [1:0] exp_sel [3] = '{2'b01, 2'b10, 2'b00};
      for (int gap = 0; gap < 3; gap++) begin
         do_reset();
         put(2'b01, 3'd3, 3'd7, 3'd7, 2'b00, 2'b00);
         tick();
         void'(ex_q.pop_front());
         for (int j = 0; j < gap; j++) begin
            put(2'b01, 3'd5, 3'd6, 3'd6, 2'b00, 2'b00);
            tick();
            void'(ex_q.pop_front());
         end
         put(2'b01, 3'd4, 3'd3, 3'd6, exp_sel[gap], 2'b00);
         tick();
         exp_e = ex_q.pop_front();
         tests_run++;
         if ({ex_valid, ex_opcode, ex_rd, fwd_a_sel, fwd_b_sel} !== {1'b1, exp_e}) begin
            tests_failed++;
            $display("FAIL fwd_distance_gap%0d: got fa=%0d fb=%0d exv=%0b required fa=%0d fb=0",
                     gap, fwd_a_sel, fwd_b_sel, ex_valid, exp_e.fa);
         end
      end
   endtask

   task automatic test_load_use();
      do_reset();
      put(2'b10, 3'd2, 3'd7, 3'd0, 2'b00, 2'b00);
      tick();
      void'(ex_q.pop_front());
      drive(2'b01, 3'd4, 3'd6, 3'd2);
      #1;
      tests_run++;
      if (in_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL load_use_ready: got %0b required 0", in_ready);
      end
      tick();
      tests_run++;
      if ({ex_valid, stall_cnt} !== {1'b0, 16'd1}) begin
         tests_failed++;
         $display("FAIL load_use_bubble: got exv=%0b cnt=%0d required exv=0 cnt=1", ex_valid, stall_cnt);
      end
      put(2'b01, 3'd4, 3'd6, 3'd2, 2'b00, 2'b10);
      tick();
      exp_e = ex_q.pop_front();
      tests_run++;
      if ({ex_valid, ex_opcode, ex_rd, fwd_a_sel, fwd_b_sel, stall_cnt} !== {1'b1, exp_e, 16'd1}) begin
         tests_failed++;
         $display("FAIL load_use_consumer: got fa=%0d fb=%0d cnt=%0d required fa=0 fb=2 cnt=1",
                  fwd_a_sel, fwd_b_sel, stall_cnt);
      end
      exp_w = wb_q.pop_front();
      tests_run++;
      if ({wb_en, wb_rd} !== {1'b1, exp_w}) begin
         tests_failed++;
         $display("FAIL load_use_wb_load: got wben=%0b wbrd=%0d required 1 %0d", wb_en, wb_rd, exp_w);
      end
      idle();
      tick();
      tests_run++;
      if (wb_en !== 1'b0) begin
         tests_failed++;
         $display("FAIL load_use_wb_bubble: got wben=%0b required 0", wb_en);
      end
      tick();
      exp_w = wb_q.pop_front();
      tests_run++;
      if ({wb_en, wb_rd} !== {1'b1, exp_w}) begin
         tests_failed++;
         $display("FAIL load_use_wb_consumer: got wben=%0b wbrd=%0d required 1 %0d", wb_en, wb_rd, exp_w);
      end
   endtask

   task automatic test_store_and_unused();
      do_reset();
      put(2'b00, 3'd5, 3'd5, 3'd5, 2'b00, 2'b00);
      tick();
      void'(ex_q.pop_front());
      put(2'b11, 3'd1, 3'd5, 3'd5, 2'b01, 2'b01);
      tick();
      exp_e = ex_q.pop_front();
      tests_run++;
      if ({ex_valid, ex_opcode, ex_rd, fwd_a_sel, fwd_b_sel} !== {1'b1, exp_e}) begin
         tests_failed++;
         $display("FAIL store_fwd: got fa=%0d fb=%0d op=%0d required fa=1 fb=1 op=3",
                  fwd_a_sel, fwd_b_sel, ex_opcode);
      end
      idle();
      tick();
      exp_w = wb_q.pop_front();
      tests_run++;
      if ({wb_en, wb_rd} !== {1'b1, exp_w}) begin
         tests_failed++;
         $display("FAIL store_producer_wb: got wben=%0b wbrd=%0d required 1 %0d", wb_en, wb_rd, exp_w);
      end
      tick();
      tests_run++;
      if (wb_en !== 1'b0) begin
         tests_failed++;
         $display("FAIL store_no_write: got wben=%0b required 0", wb_en);
      end
      do_reset();
      put(2'b10, 3'd2, 3'd7, 3'd7, 2'b00, 2'b00);
      tick();
      void'(ex_q.pop_front());
      put(2'b10, 3'd1, 3'd7, 3'd2, 2'b00, 2'b00);
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL unused_rt_no_hazard: got rdy=%0b required 1", in_ready);
      end
      tick();
      void'(ex_q.pop_front());
      put(2'b00, 3'd6, 3'd1, 3'd1, 2'b00, 2'b00);
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL unused_src_no_hazard: got rdy=%0b required 1", in_ready);
      end
      tick();
      exp_e = ex_q.pop_front();
      tests_run++;
      if ({ex_valid, ex_opcode, ex_rd, fwd_a_sel, fwd_b_sel} !== {1'b1, exp_e}) begin
         tests_failed++;
         $display("FAIL unused_src_sel: got fa=%0d fb=%0d exv=%0b required fa=0 fb=0 exv=1",
                  fwd_a_sel, fwd_b_sel, ex_valid);
      end
   endtask

   task automatic test_flush();
      do_reset();
      put(2'b01, 3'd1, 3'd7, 3'd7, 2'b00, 2'b00);
      tick();
      put(2'b10, 3'd2, 3'd7, 3'd7, 2'b00, 2'b00);
      tick();
      drive(2'b01, 3'd4, 3'd6, 3'd2);
      flush = 1'b1;
      #1;
      tests_run++;
      if (in_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush_ready: got %0b required 0", in_ready);
      end
      tick();
      tests_run++;
      if ({ex_valid, mem_valid, stall_cnt} !== {1'b0, 1'b0, 16'd0}) begin
         tests_failed++;
         $display("FAIL flush_kill: got exv=%0b memv=%0b cnt=%0d required 0 0 0",
                  ex_valid, mem_valid, stall_cnt);
      end
      exp_w = wb_q.pop_front();
      tests_run++;
      if ({wb_en, wb_rd} !== {1'b1, exp_w}) begin
         tests_failed++;
         $display("FAIL flush_older_wb: got wben=%0b wbrd=%0d required 1 %0d", wb_en, wb_rd, exp_w);
      end
      wb_q.delete();
      idle();
      for (int i = 0; i < 2; i++) begin
         tick();
         tests_run++;
         if (wb_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_killed_no_wb: cycle %0d got wben=%0b wbrd=%0d required 0", i, wb_en, wb_rd);
         end
      end
   endtask

   task automatic test_back_to_back();
      stim_t tbl [7] = '{
         '{2'b01, 3'd1, 3'd7, 3'd7, 2'b00, 2'b00},
         '{2'b01, 3'd2, 3'd1, 3'd1, 2'b01, 2'b01},
         '{2'b01, 3'd3, 3'd1, 3'd2, 2'b10, 2'b01},
         '{2'b11, 3'd3, 3'd3, 3'd1, 2'b01, 2'b00},
         '{2'b00, 3'd4, 3'd0, 3'd0, 2'b00, 2'b00},
         '{2'b01, 3'd5, 3'd4, 3'd3, 2'b01, 2'b00},
         '{2'b01, 3'd6, 3'd5, 3'd4, 2'b01, 2'b10}
      };
      do_reset();
      for (int i = 0; i < 9; i++) begin
         if (i < 7) put(tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].rt, tbl[i].fa, tbl[i].fb);
         else idle();
         tick();
         if (i < 7) begin
            exp_e = ex_q.pop_front();
            tests_run++;
            if ({ex_valid, ex_opcode, ex_rd, fwd_a_sel, fwd_b_sel} !== {1'b1, exp_e}) begin
               tests_failed++;
               $display("FAIL b2b_ex_%0d: got %h required %h", i,
                        {ex_valid, ex_opcode, ex_rd, fwd_a_sel, fwd_b_sel}, {1'b1, exp_e});
            end
         end
         if (i >= 2) begin
            tests_run++;
            if (tbl[i-2].op == 2'b11) begin
               if (wb_en !== 1'b0) begin
                  tests_failed++;
                  $display("FAIL b2b_wb_%0d: got wben=%0b required 0 for store", i, wb_en);
               end
            end else begin
               exp_w = wb_q.pop_front();
               if ({wb_en, wb_rd} !== {1'b1, exp_w}) begin
                  tests_failed++;
                  $display("FAIL b2b_wb_%0d: got wben=%0b wbrd=%0d required 1 %0d", i, wb_en, wb_rd, exp_w);
               end
            end
         end
      end
   endtask

   task automatic test_saturate();
      do_reset();
      for (int i = 0; i < 65540; i++) begin
         drive(2'b10, 3'd2, 3'd7, 3'd7);
         tick();
         drive(2'b01, 3'd4, 3'd6, 3'd2);
         tick();
         if (i == 9 || i == 65534) begin
            tests_run++;
            if (stall_cnt !== ((i == 9) ? 16'd10 : 16'hFFFF)) begin
               tests_failed++;
               $display("FAIL stall_count_%0d: got %0d required %0d", i, stall_cnt,
                        (i == 9) ? 16'd10 : 16'hFFFF);
            end
         end
      end
      idle();
      tests_run++;
      if (stall_cnt !== 16'hFFFF) begin
         tests_failed++;
         $display("FAIL stall_saturate: got %h required ffff", stall_cnt);
      end
   endtask

   initial begin
      idle();
      test_reset();
      test_forward_distance();
      test_load_use();
      test_store_and_unused();
      test_flush();
      test_back_to_back();
      test_saturate();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
